// File: rtl/engine_scheduler_pkg.sv
// Shared types and defaults for the Mandelbrot pixel scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

    localparam int DEFAULT_FRAME_WIDTH  = 640;
    localparam int DEFAULT_FRAME_HEIGHT = 480;

endpackage

// File: rtl/engine_scheduler_if.sv
// Engine-array side of the scheduler: dispatch strobes and the single result port.
interface engine_scheduler_if #(
    parameter int NUM_ENGINES      = 30,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int IDX_WIDTH        = $clog2(NUM_ENGINES)
);
    logic [NUM_ENGINES-1:0]      eng_idle;
    logic [NUM_ENGINES-1:0]      eng_start;
    logic [PIXEL_DATA_WIDTH-1:0] eng_x;
    logic [PIXEL_DATA_WIDTH-1:0] eng_y;
    logic [NUM_ENGINES-1:0]      eng_done;
    logic [NUM_ENGINES-1:0]      eng_ack;
    logic                        out_valid;
    logic [IDX_WIDTH-1:0]        out_sel;
    logic                        out_ready;

    // Result port: a transfer happens on a cycle with out_valid & out_ready; once
    // out_valid rises, out_sel stays fixed and out_valid stays high until that transfer.
    modport master (
        input  eng_idle, eng_done, out_ready,
        output eng_start, eng_x, eng_y, eng_ack, out_valid, out_sel
    );

    modport slave (
        output eng_idle, eng_done, out_ready,
        input  eng_start, eng_x, eng_y, eng_ack, out_valid, out_sel
    );
endinterface

// File: rtl/engine_scheduler_rr_arbiter.sv
// Round-robin priority pick: first request at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);
    always_comb begin : p_pick
        int j;
        j          = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any           = 1'b1;
                gnt_idx       = IDX_W'(j);
                gnt_onehot[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/engine_scheduler.sv
// Raster-order pixel dispatcher and round-robin result collector for the engine array.
module engine_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_ENGINES      = 30,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int IDX_WIDTH        = $clog2(NUM_ENGINES),
    parameter int FRAME_WIDTH      = DEFAULT_FRAME_WIDTH,
    parameter int FRAME_HEIGHT     = DEFAULT_FRAME_HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    output sched_state_t       dbg_state,
    engine_scheduler_if.master bus
);
    if (FRAME_WIDTH > (1 << PIXEL_DATA_WIDTH) || FRAME_HEIGHT > (1 << PIXEL_DATA_WIDTH)) begin : g_bad_frame
        $error("frame dimensions exceed PIXEL_DATA_WIDTH coordinate range");
    end
    if (NUM_ENGINES < 2) begin : g_bad_engines
        $error("NUM_ENGINES must be at least 2");
    end

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = PIXEL_DATA_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = PIXEL_DATA_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [IDX_WIDTH-1:0]        IDX_LAST = IDX_WIDTH'(NUM_ENGINES - 1);

    function automatic logic [IDX_WIDTH-1:0] idx_inc(input logic [IDX_WIDTH-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    sched_state_t                state_q;
    logic [PIXEL_DATA_WIDTH-1:0] px_q, py_q, x_q, y_q;
    logic [NUM_ENGINES-1:0]      busy_q;
    logic [IDX_WIDTH-1:0]        dp_q, rp_q, lock_idx_q;
    logic                        lock_q;

    logic [NUM_ENGINES-1:0] eligible, d_onehot, disp_mask;
    logic [NUM_ENGINES-1:0] candidates, r_onehot, sel_onehot, ack_mask;
    logic [IDX_WIDTH-1:0]   d_idx, r_idx, sel;
    logic                   d_any, r_any, dispatching, valid, retiring, last_pixel;

    assign eligible   = bus.eng_idle & ~busy_q;
    assign candidates = bus.eng_done & busy_q;

    rr_arbiter #(.N(NUM_ENGINES), .IDX_W(IDX_WIDTH)) u_disp_arb (
        .req(eligible), .ptr(dp_q), .gnt_onehot(d_onehot), .gnt_idx(d_idx), .any(d_any)
    );

    rr_arbiter #(.N(NUM_ENGINES), .IDX_W(IDX_WIDTH)) u_ret_arb (
        .req(candidates), .ptr(rp_q), .gnt_onehot(r_onehot), .gnt_idx(r_idx), .any(r_any)
    );

    assign dispatching = (state_q == DISPATCH) && d_any;
    assign disp_mask   = dispatching ? d_onehot : '0;
    assign last_pixel  = (px_q == X_LAST) && (py_q == Y_LAST);

    // A stalled offer keeps its engine even if a higher-priority candidate shows up.
    assign valid      = (state_q != IDLE) && (lock_q || r_any);
    assign sel        = lock_q ? lock_idx_q : r_idx;
    assign sel_onehot = lock_q ? (NUM_ENGINES'(1) << lock_idx_q) : r_onehot;
    assign retiring   = valid && bus.out_ready;
    assign ack_mask   = retiring ? sel_onehot : '0;

    assign bus.eng_start = disp_mask;
    assign bus.eng_x     = dispatching ? px_q : x_q;
    assign bus.eng_y     = dispatching ? py_q : y_q;
    assign bus.eng_ack   = ack_mask;
    assign bus.out_valid = valid;
    assign bus.out_sel   = valid ? sel : '0;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign dbg_state     = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= '0;
            dp_q       <= '0;
            rp_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            busy_q <= (busy_q | disp_mask) & ~ack_mask;

            if (retiring) begin
                rp_q   <= idx_inc(sel);
                lock_q <= 1'b0;
            end else if (valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end

            if (dispatching) begin
                dp_q <= idx_inc(d_idx);
                x_q  <= px_q;
                y_q  <= py_q;
                if (px_q == X_LAST) begin
                    px_q <= '0;
                    py_q <= last_pixel ? '0 : py_q + 1'b1;
                end else begin
                    px_q <= px_q + 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DISPATCH;
                        px_q    <= '0;
                        py_q    <= '0;
                    end
                end
                DISPATCH: if (dispatching && last_pixel) state_q <= DRAIN;
                DRAIN:    if (busy_q == '0) state_q <= DONE;
                DONE:     state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_engine_scheduler.sv
// Bench for engine_scheduler: 4 engines on a 4x2 frame, vector table plus scoreboarded full frame.
module tb_engine_scheduler;
    import sched_pkg::*;

    localparam int NE = 4;
    localparam int PW = 10;
    localparam int IW = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         frame_done;
    sched_state_t dut_state;

    engine_scheduler_if #(.NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW), .IDX_WIDTH(IW)) bus ();

    engine_scheduler #(
        .NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW), .IDX_WIDTH(IW),
        .FRAME_WIDTH(4), .FRAME_HEIGHT(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .frame_done(frame_done), .dbg_state(dut_state), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_in(input logic s, input logic [NE-1:0] idle, input logic [NE-1:0] done, input logic rdy);
        start         = s;
        bus.eng_idle  = idle;
        bus.eng_done  = done;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_in(1'b0, '0, '0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic          start;
        logic [NE-1:0] idle;
        logic [NE-1:0] done;
        logic          ready;
        logic [NE-1:0] e_start;
        logic [PW-1:0] e_x;
        logic [PW-1:0] e_y;
        logic [NE-1:0] e_ack;
        logic          e_valid;
        logic [IW-1:0] e_sel;
        logic          e_busy;
        logic          e_fdone;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic [NE-1:0] idle, input logic [NE-1:0] done,
                       input logic rdy, input logic [NE-1:0] es, input int ex, input int ey,
                       input logic [NE-1:0] ea, input logic ev, input int esel,
                       input logic eb, input logic efd);
        vec_t v;
        v.start = s; v.idle = idle; v.done = done; v.ready = rdy;
        v.e_start = es; v.e_x = PW'(ex); v.e_y = PW'(ey); v.e_ack = ea;
        v.e_valid = ev; v.e_sel = IW'(esel); v.e_busy = eb; v.e_fdone = efd;
        tbl.push_back(v);
    endtask

    // Scoreboard state for the full-frame run.
    logic [2*PW-1:0] exp_q[$];
    logic [NE-1:0]   m_busy;
    int              m_cnt[NE];

    initial begin
        reset = 1'b0;
        drive_in(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset mid-DISPATCH with three engines busy.
        @(negedge clk);
        drive_in(1'b1, 4'b0111, 4'b0000, 1'b1);
        repeat (4) begin
            @(negedge clk);
            drive_in(1'b0, 4'b0111, 4'b0000, 1'b1);
        end
        drive_in(1'b0, 4'b1111, 4'b0001, 1'b1);
        #1;
        chk("pre_rst_start", bus.eng_start, 4'b1000);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_eng_start", bus.eng_start, 0);
        chk("rst_eng_x", bus.eng_x, 0);
        chk("rst_eng_y", bus.eng_y, 0);
        chk("rst_eng_ack", bus.eng_ack, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sel", bus.out_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        reset = 1'b1;
        drive_in(1'b0, 4'b1111, 4'b1111, 1'b1);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_state", dut_state, IDLE);
        chk("post_rst_valid", bus.out_valid, 0);

        // Dispatch burst, retire pair, stalled lock, drain with ignored start, restart.
        add(1, 4'hF, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0001, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0010, 1, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0100, 2, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b1000, 3, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0000, 3, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b1010, 1, 4'b0000, 3, 0, 4'b0010, 1, 1, 1, 0);
        add(0, 4'hF, 4'b1000, 1, 4'b0010, 0, 1, 4'b1000, 1, 3, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b1000, 1, 1, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            add(0, 4'hF, 4'b0100, 0, 4'b0000, 1, 1, 4'b0000, 1, 2, 1, 0);
        add(0, 4'hF, 4'b0101, 0, 4'b0000, 1, 1, 4'b0000, 1, 2, 1, 0);
        add(0, 4'hF, 4'b0101, 1, 4'b0000, 1, 1, 4'b0100, 1, 2, 1, 0);
        add(0, 4'hF, 4'b0001, 1, 4'b0100, 2, 1, 4'b0001, 1, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0001, 3, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 4'hF, 4'b0000, 1, 4'b0000, 3, 1, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b1111, 1, 4'b0000, 3, 1, 4'b0010, 1, 1, 1, 0);
        add(0, 4'hF, 4'b1101, 1, 4'b0000, 3, 1, 4'b0100, 1, 2, 1, 0);
        add(0, 4'hF, 4'b1001, 1, 4'b0000, 3, 1, 4'b1000, 1, 3, 1, 0);
        add(0, 4'hF, 4'b0001, 1, 4'b0000, 3, 1, 4'b0001, 1, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0000, 3, 1, 4'b0000, 0, 0, 1, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0000, 3, 1, 4'b0000, 0, 0, 1, 1);
        add(1, 4'hF, 4'b0000, 1, 4'b0000, 3, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'hF, 4'b0000, 1, 4'b0010, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 4'h0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive_in(tbl[k].start, tbl[k].idle, tbl[k].done, tbl[k].ready);
            #1;
            chk($sformatf("v%0d_eng_start", k), bus.eng_start, tbl[k].e_start);
            chk($sformatf("v%0d_eng_x", k), bus.eng_x, tbl[k].e_x);
            chk($sformatf("v%0d_eng_y", k), bus.eng_y, tbl[k].e_y);
            chk($sformatf("v%0d_eng_ack", k), bus.eng_ack, tbl[k].e_ack);
            chk($sformatf("v%0d_out_valid", k), bus.out_valid, tbl[k].e_valid);
            chk($sformatf("v%0d_out_sel", k), bus.out_sel, tbl[k].e_sel);
            chk($sformatf("v%0d_busy", k), busy, tbl[k].e_busy);
            chk($sformatf("v%0d_frame_done", k), frame_done, tbl[k].e_fdone);
        end

        // Full frame: engines finish 3 cycles after dispatch, downstream stalls randomly.
        do_reset();
        begin
            int cyc, n_start, n_ack, n_fd, fd_cyc, last_ack;
            logic prev_lock;
            logic [IW-1:0] prev_sel;
            logic [NE-1:0] done_mask;
            cyc = 0; n_start = 0; n_ack = 0; n_fd = 0; fd_cyc = -1; last_ack = -1;
            prev_lock = 1'b0; prev_sel = '0;
            m_busy = '0;
            for (int i = 0; i < NE; i++) m_cnt[i] = 0;
            for (int y = 0; y < 2; y++)
                for (int x = 0; x < 4; x++)
                    exp_q.push_back({PW'(y), PW'(x)});

            while (cyc < 300 && !(fd_cyc >= 0 && cyc > fd_cyc + 2)) begin
                @(negedge clk);
                done_mask = '0;
                for (int i = 0; i < NE; i++) begin
                    if (m_busy[i] && m_cnt[i] != 0) m_cnt[i]--;
                    if (m_busy[i] && m_cnt[i] == 0) done_mask[i] = 1'b1;
                end
                drive_in(cyc == 0, ~m_busy, done_mask, $urandom_range(0, 3) != 0);
                #1;
                if (prev_lock) chk("lock_sel", bus.out_sel, prev_sel);
                prev_lock = bus.out_valid && !bus.out_ready;
                prev_sel  = bus.out_sel;
                if (bus.eng_start != '0) begin
                    n_start++;
                    chk("disp_target", $onehot(bus.eng_start) && ((bus.eng_start & m_busy) == '0), 1);
                    if (exp_q.size() == 0) begin
                        chk("disp_extra", n_start, 8);
                    end else begin
                        chk("disp_xy", {bus.eng_y, bus.eng_x}, exp_q.pop_front());
                    end
                    for (int i = 0; i < NE; i++)
                        if (bus.eng_start[i]) begin
                            m_busy[i] = 1'b1;
                            m_cnt[i]  = 3;
                        end
                end
                if (bus.eng_ack != '0) begin
                    n_ack++;
                    last_ack = cyc;
                    chk("ack_target", $onehot(bus.eng_ack) && ((bus.eng_ack & done_mask) == bus.eng_ack)
                        && bus.eng_ack[bus.out_sel], 1);
                    m_busy = m_busy & ~bus.eng_ack;
                end
                if (fd_cyc >= 0 && cyc == fd_cyc + 1) chk("busy_fall", busy, 0);
                if (frame_done) begin
                    n_fd++;
                    fd_cyc = cyc;
                end
                cyc++;
            end
            chk("frame_timeout", fd_cyc >= 0, 1);
            chk("start_count", n_start, 8);
            chk("ack_count", n_ack, 8);
            chk("pixels_left", exp_q.size(), 0);
            chk("frame_done_count", n_fd, 1);
            chk("frame_done_delay", fd_cyc - last_ack, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/engine_scheduler.md
Name: engine_scheduler

Overview:
Pixel scheduler for the Mandelbrot engine array. On start it walks the frame in raster order and issues each pixel coordinate to an idle engine, choosing round-robin. It also arbitrates finished engines onto a single result port, also round-robin, and signals frame completion once every issued pixel has retired. It sits between the frame controller and the NUM_ENGINES engine/queue slices.

Parameters:
NUM_ENGINES, 30, number of engine slices served
PIXEL_DATA_WIDTH, 10, width of pixel x/y coordinates
IDX_WIDTH, $clog2(NUM_ENGINES), width of engine index
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 480, lines per frame

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a frame; sampled only in IDLE
eng_idle  in  NUM_ENGINES  engine i can accept a pixel
eng_start  out  NUM_ENGINES  one-hot, single-cycle dispatch strobe
eng_x  out  PIXEL_DATA_WIDTH  pixel x for the strobed engine
eng_y  out  PIXEL_DATA_WIDTH  pixel y for the strobed engine
eng_done  in  NUM_ENGINES  engine i holds a finished result
eng_ack  out  NUM_ENGINES  one-hot, single-cycle retire strobe
out_valid  out  1  result from engine out_sel is offered
out_sel  out  IDX_WIDTH  index of the engine being retired
out_ready  in  1  downstream accepts the result
busy  out  1  high whenever state is not IDLE
frame_done  out  1  single-cycle pulse at frame end

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; px=0, py=0; busy_q=0; both round-robin pointers=0. All outputs are 0.
- Internal busy_q[NUM_ENGINES]: the bit is set on dispatch and cleared on retire. This register is authoritative.
- States:
  - IDLE: start=1 moves to DISPATCH next cycle with px=py=0.
  - DISPATCH: issues pixels as described below. The cycle that dispatches (FRAME_WIDTH-1, FRAME_HEIGHT-1) moves to DRAIN.
  - DRAIN: no dispatch. Moves to DONE when busy_q==0.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Dispatch (DISPATCH only):
  - eligible = eng_idle & ~busy_q.
  - Grant the first eligible index at or above dispatch pointer dp, wrapping modulo NUM_ENGINES.
  - Same cycle, combinationally: eng_start[g]=1, eng_x=px, eng_y=py. The engine captures on the next edge.
  - On the clock edge: set busy_q[g]; dp=(g+1) mod NUM_ENGINES; advance px.
  - px wraps at FRAME_WIDTH-1 to 0 with py+1.
  - Maximum one dispatch per cycle; zero-latency grant.
  - No eligible engine: eng_start=0, px/py/dp hold.
  - eng_x/eng_y hold their last value when not strobed.
- Retire (any state except IDLE):
  - candidates = eng_done & busy_q.
  - Grant first candidate at or above retire pointer rp, wrapping.
  - out_valid=1, out_sel=grant index.
  - Grant is locked while out_valid & ~out_ready: out_sel is stable until accepted, even if a lower-numbered candidate appears.
  - On out_valid & out_ready: eng_ack[sel]=1 that cycle; clear busy_q[sel] at the edge; rp=(sel+1) mod NUM_ENGINES.
  - eng_done on a non-busy engine is ignored.
- Simultaneous events:
  - Dispatch and retire in the same cycle are independent and never target the same engine, because dispatch requires ~busy_q.
  - A retired engine is eligible for dispatch no earlier than the following cycle.
- DRAIN to DONE is evaluated on the registered busy_q. A final retire in cycle t therefore gives DONE in cycle t+2 and frame_done in cycle t+2.
- Reset mid-frame discards all tracking. Engines and queues are reset separately.
- Width rules:
  - px/py are PIXEL_DATA_WIDTH unsigned.
  - FRAME_WIDTH and FRAME_HEIGHT must each be at most 2^PIXEL_DATA_WIDTH; elaboration fails otherwise.
  - NUM_ENGINES must be at least 2.

Decomposition:
- Package sched_pkg holds:
  - state enum sched_state_t {IDLE, DISPATCH, DRAIN, DONE};
  - default frame dimension constants.
- One sub-module, rr_arbiter (params N, IDX_W):
  - inputs: req, ptr
  - outputs: gnt_onehot, gnt_idx, any
- engine_scheduler instantiates rr_arbiter twice: once for dispatch, once for retire. The retire instance is wrapped with the lock register.

Test Plan:
Bench uses NUM_ENGINES=4, FRAME_WIDTH=4, FRAME_HEIGHT=2.
1. Reset low mid-DISPATCH with busy_q=4'b0111 -> within the same cycle all outputs are 0; after release, busy=0 and state is IDLE.
2. All eng_idle=1, start pulse -> eng_start sequence 0001,0010,0100,1000 on consecutive cycles with (x,y)=(0,0),(1,0),(2,0),(3,0); then stalls with eng_start=0 because all engines are busy.
3. eng_done=4'b1010, rp=0, out_ready=1 -> out_sel=1 then out_sel=3 on consecutive cycles; eng_ack=0010 then 1000; engine 1 redispatched with (0,1) no earlier than the cycle after its ack.
4. out_ready=0 for 5 cycles with done=0100, then done=0101 -> out_sel holds at 2 throughout; after out_ready rises, 2 retires, then 0.
5. Full 8-pixel frame with engines completing 3 cycles after dispatch -> exactly 8 eng_start and 8 eng_ack strobes; each (x,y) appears once, in raster order; frame_done pulses once, 2 cycles after the last ack; busy falls next cycle.
6. start asserted during DRAIN -> ignored: no new dispatch, px/py unchanged; a start after frame_done begins a new frame at (0,0).
